// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int ADDR_W         = 32;
  localparam int WORD_W         = 32;
  localparam int DEF_LINES      = 32;
  localparam int DEF_LINE_WORDS = 4;
  localparam int OFF_W          = $clog2(DEF_LINE_WORDS);
  localparam int IDX_W          = $clog2(DEF_LINES);
  localparam int TAG_W          = ADDR_W - IDX_W - OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    DONE      = 2'd3
  } state_t;

  // Right-justified bit field [lsb +: width] of an address.
  function automatic logic [ADDR_W-1:0] addr_field(input logic [ADDR_W-1:0] addr,
                                                   input int lsb, input int width);
    return (addr >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

  // Clears the low lsb bits, giving the line-aligned byte address.
  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr,
                                                  input int lsb);
    return addr & ~((32'd1 << lsb) - 32'd1);
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side request/response and backing-memory line handshake of the data cache.
interface dcache_if #(
  parameter int LINE_W = 128
);
  logic [31:0]       addr_i;
  logic [31:0]       wdata_i;
  logic              read_i;
  logic              write_i;
  logic [31:0]       rdata_o;
  logic              stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [31:0]       mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic [LINE_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  modport slave (
    input  addr_i, wdata_i, read_i, write_i, mem_rdata_i, mem_ack_i,
    output rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output addr_i, wdata_i, read_i, write_i, mem_rdata_i, mem_ack_i,
    input  rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data arrays: one combinational read port, word-write and line-fill paths.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int LINES      = DEF_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  localparam int LINE_W    = 32 * LINE_WORDS,
  localparam int OFF_BITS  = $clog2(LINE_WORDS),
  localparam int IDX_BITS  = $clog2(LINES),
  localparam int TAG_BITS  = 32 - IDX_BITS - OFF_BITS - 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [LINE_W-1:0]   rd_line,
  input  logic                ww_en,
  input  logic [IDX_BITS-1:0] ww_idx,
  input  logic [OFF_BITS-1:0] ww_off,
  input  logic [31:0]         ww_data,
  input  logic                fill_en,
  input  logic [IDX_BITS-1:0] fill_idx,
  input  logic [TAG_BITS-1:0] fill_tag,
  input  logic [LINE_W-1:0]   fill_line,
  input  logic                clr_en,
  input  logic [IDX_BITS-1:0] clr_idx
);

  logic [LINES-1:0]    valid_reg, valid_next;
  logic [LINES-1:0]    dirty_reg, dirty_next;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [LINE_W-1:0]   data_mem [LINES];

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line
      logic fill_sel, ww_sel, clr_sel;
      assign fill_sel = fill_en && (fill_idx == IDX_BITS'(gi));
      assign ww_sel   = ww_en   && (ww_idx   == IDX_BITS'(gi));
      assign clr_sel  = clr_en  && (clr_idx  == IDX_BITS'(gi));
      assign valid_next[gi] = fill_sel | valid_reg[gi];
      // A fill always lands clean; a word write marks the line dirty.
      assign dirty_next[gi] = fill_sel ? 1'b0 :
                              ww_sel   ? 1'b1 :
                              clr_sel  ? 1'b0 : dirty_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      dirty_reg <= dirty_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= fill_line;
    end else if (ww_en) begin
      data_mem[ww_idx][{ww_off, 5'd0} +: 32] <= ww_data;
    end
  end

  assign rd_valid = valid_reg[rd_idx];
  assign rd_dirty = dirty_reg[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller for the MEM stage.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES      = 32,
  parameter int LINE_WORDS = 4,
  parameter int LINE_W     = 32 * LINE_WORDS
) (
  input  logic     clk_i,
  input  logic     rst_i,
  dcache_if.slave  bus
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(LINES);
  localparam int TAG_BITS = 32 - IDX_BITS - OFF_BITS - 2;
  localparam int LSB_IDX  = OFF_BITS + 2;
  localparam int LSB_TAG  = LSB_IDX + IDX_BITS;

  state_t      state_reg, state_next;
  logic [31:0] miss_addr_reg, miss_addr_next;

  logic [OFF_BITS-1:0] cpu_off;
  logic [IDX_BITS-1:0] cpu_idx, miss_idx, rd_idx;
  logic [TAG_BITS-1:0] cpu_tag, miss_tag, rd_tag;
  logic                rd_valid, rd_dirty;
  logic [LINE_W-1:0]   rd_line;
  logic [31:0]         rd_word;
  logic                req_any, hit;

  logic              mem_req, mem_we;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              ww_en, fill_en, clr_en;

  assign cpu_off  = OFF_BITS'(addr_field(bus.addr_i, 2, OFF_BITS));
  assign cpu_idx  = IDX_BITS'(addr_field(bus.addr_i, LSB_IDX, IDX_BITS));
  assign cpu_tag  = TAG_BITS'(addr_field(bus.addr_i, LSB_TAG, TAG_BITS));
  assign miss_idx = IDX_BITS'(addr_field(miss_addr_reg, LSB_IDX, IDX_BITS));
  assign miss_tag = TAG_BITS'(addr_field(miss_addr_reg, LSB_TAG, TAG_BITS));

  // Outside IDLE the store must keep pointing at the latched miss line,
  // even if the CPU drops or changes its request while stalled.
  assign rd_idx  = (state_reg == IDLE) ? cpu_idx : miss_idx;
  assign rd_word = rd_line[{cpu_off, 5'd0} +: 32];

  assign req_any = bus.read_i | bus.write_i;
  assign hit     = req_any & rd_valid & (rd_tag == cpu_tag) & (state_reg == IDLE);

  dcache_line_store #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_store (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_idx    (rd_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .ww_en     (ww_en),
    .ww_idx    (cpu_idx),
    .ww_off    (cpu_off),
    .ww_data   (bus.wdata_i),
    .fill_en   (fill_en),
    .fill_idx  (miss_idx),
    .fill_tag  (miss_tag),
    .fill_line (bus.mem_rdata_i),
    .clr_en    (clr_en),
    .clr_idx   (miss_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      miss_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      miss_addr_reg <= miss_addr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    miss_addr_next = miss_addr_reg;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    ww_en          = 1'b0;
    fill_en        = 1'b0;
    clr_en         = 1'b0;
    case (state_reg)
      IDLE: begin
        ww_en = hit & bus.write_i;
        if (req_any && !hit) begin
          miss_addr_next = bus.addr_i;
          state_next     = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {rd_tag, miss_idx, {LSB_IDX{1'b0}}};
        mem_wdata = rd_line;
        if (bus.mem_ack_i) begin
          clr_en     = 1'b1;
          state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = line_base(miss_addr_reg, LSB_IDX);
        if (bus.mem_ack_i) begin
          fill_en    = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.rdata_o     = (hit && !bus.write_i) ? rd_word : 32'h0;
  assign bus.stall_o     = req_any & ~hit;
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: misses, hits, evictions, reset abort and a held-off ack.
module tb_dcache_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dcache_if #(.LINE_W(128)) bus ();

  dcache_ctrl #(
    .LINES      (32),
    .LINE_WORDS (4),
    .LINE_W     (128)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic cpu(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.read_i  = rd;
    bus.write_i = wr;
    bus.addr_i  = a;
    bus.wdata_i = d;
  endtask

  task automatic ack(input logic a, input logic [127:0] line);
    bus.mem_ack_i   = a;
    bus.mem_rdata_i = line;
  endtask

  initial begin
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    ack(1'b0, 128'h0);
    tick();
    tick();
    rst = 1'b0;
    settle();
    $display("txn: reset");
    chk("rst_stall", bus.stall_o, 1'b0);
    chk("rst_req", bus.mem_req_o, 1'b0);
    chk("rst_we", bus.mem_we_o, 1'b0);
    chk("rst_addr", bus.mem_addr_o, 32'h0);
    chk("rst_wdata", bus.mem_wdata_o, 128'h0);
    chk("rst_rdata", bus.rdata_o, 32'h0);

    // Cold read miss at 0x10, ack 3 cycles after req rises.
    $display("txn: cold read 0x10");
    cpu(1'b1, 1'b0, 32'h10, 32'h0);
    settle();
    chk("cold_idle_stall", bus.stall_o, 1'b1);
    chk("cold_idle_req", bus.mem_req_o, 1'b0);
    tick();
    chk("cold_alloc_req", bus.mem_req_o, 1'b1);
    chk("cold_alloc_we", bus.mem_we_o, 1'b0);
    chk("cold_alloc_addr", bus.mem_addr_o, 32'h10);
    chk("cold_alloc_stall", bus.stall_o, 1'b1);
    tick();
    chk("cold_alloc_req2", bus.mem_req_o, 1'b1);
    tick();
    chk("cold_alloc_req3", bus.mem_req_o, 1'b1);
    tick();
    ack(1'b1, {32'h33, 32'h22, 32'h11, 32'h00});
    settle();
    chk("cold_ack_stall", bus.stall_o, 1'b1);
    tick();
    ack(1'b0, 128'h0);
    settle();
    chk("cold_done_req", bus.mem_req_o, 1'b0);
    chk("cold_done_stall", bus.stall_o, 1'b1);
    tick();
    chk("cold_hit_stall", bus.stall_o, 1'b0);
    chk("cold_hit_rdata", bus.rdata_o, 32'h0);

    $display("txn: read hit 0x14");
    cpu(1'b1, 1'b0, 32'h14, 32'h0);
    settle();
    chk("hit_stall", bus.stall_o, 1'b0);
    chk("hit_rdata", bus.rdata_o, 32'h11);
    chk("hit_req", bus.mem_req_o, 1'b0);

    $display("txn: write hit 0x14");
    cpu(1'b0, 1'b1, 32'h14, 32'hDEADBEEF);
    settle();
    chk("wr_stall", bus.stall_o, 1'b0);
    chk("wr_rdata", bus.rdata_o, 32'h0);
    tick();
    cpu(1'b1, 1'b0, 32'h14, 32'h0);
    settle();
    chk("wr_readback", bus.rdata_o, 32'hDEADBEEF);

    // 0x210 maps to index 1 with tag 1: dirty victim goes out first.
    $display("txn: dirty eviction read 0x210");
    cpu(1'b1, 1'b0, 32'h210, 32'h0);
    settle();
    chk("dirty_stall", bus.stall_o, 1'b1);
    tick();
    chk("wb_req", bus.mem_req_o, 1'b1);
    chk("wb_we", bus.mem_we_o, 1'b1);
    chk("wb_addr", bus.mem_addr_o, 32'h10);
    chk("wb_wdata", bus.mem_wdata_o, {32'h33, 32'h22, 32'hDEADBEEF, 32'h00});
    tick();
    chk("wb_hold_addr", bus.mem_addr_o, 32'h10);
    chk("wb_hold_we", bus.mem_we_o, 1'b1);
    ack(1'b1, 128'h0);
    tick();
    ack(1'b0, 128'h0);
    settle();
    chk("wb_alloc_req", bus.mem_req_o, 1'b1);
    chk("wb_alloc_we", bus.mem_we_o, 1'b0);
    chk("wb_alloc_addr", bus.mem_addr_o, 32'h210);
    ack(1'b1, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    tick();
    ack(1'b0, 128'h0);
    settle();
    chk("wb_done_req", bus.mem_req_o, 1'b0);
    tick();
    chk("wb_hit_stall", bus.stall_o, 1'b0);
    chk("wb_hit_rdata", bus.rdata_o, 32'hA0);

    $display("txn: clean eviction read 0x410");
    cpu(1'b1, 1'b0, 32'h410, 32'h0);
    settle();
    chk("clean_stall", bus.stall_o, 1'b1);
    tick();
    chk("clean_req", bus.mem_req_o, 1'b1);
    chk("clean_we", bus.mem_we_o, 1'b0);
    chk("clean_addr", bus.mem_addr_o, 32'h410);
    ack(1'b1, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    tick();
    ack(1'b0, 128'h0);
    tick();
    chk("clean_hit_rdata", bus.rdata_o, 32'hB0);

    $display("txn: reset during allocate of 0x20");
    cpu(1'b1, 1'b0, 32'h20, 32'h0);
    tick();
    chk("rsta_req", bus.mem_req_o, 1'b1);
    chk("rsta_addr", bus.mem_addr_o, 32'h20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ack(1'b1, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    settle();
    chk("rsta_req_dropped", bus.mem_req_o, 1'b0);
    chk("rsta_stall", bus.stall_o, 1'b1);
    tick();
    ack(1'b0, 128'h0);
    settle();
    chk("rsta_remiss_req", bus.mem_req_o, 1'b1);
    chk("rsta_remiss_addr", bus.mem_addr_o, 32'h20);

    $display("txn: ack held off 20 cycles");
    for (int i = 0; i < 20; i++) begin
      chk("hold_stall", bus.stall_o, 1'b1);
      chk("hold_req", bus.mem_req_o, 1'b1);
      chk("hold_addr", bus.mem_addr_o, 32'h20);
      tick();
    end
    ack(1'b1, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
    tick();
    ack(1'b0, 128'h0);
    settle();
    chk("hold_done_req", bus.mem_req_o, 1'b0);
    tick();
    chk("hold_hit_stall", bus.stall_o, 1'b0);
    chk("hold_hit_rdata", bus.rdata_o, 32'hD0);

    $display("txn: write+read together at 0x24");
    cpu(1'b1, 1'b1, 32'h24, 32'h12345678);
    settle();
    chk("prec_stall", bus.stall_o, 1'b0);
    chk("prec_rdata", bus.rdata_o, 32'h0);
    tick();
    cpu(1'b1, 1'b0, 32'h24, 32'h0);
    settle();
    chk("prec_readback", bus.rdata_o, 32'h12345678);
    cpu(1'b0, 1'b0, 32'h24, 32'h0);
    settle();
    chk("idle_stall", bus.stall_o, 1'b0);
    chk("idle_rdata", bus.rdata_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
